rom_cpu: RTL and testbench

- 16 x 8 read-only program/data memory for the small teaching CPU; holds a fixed program image.
- Sits between the CPU's 4-bit program counter/address mux and its instruction/operand register.
- Synchronous read: the addressed byte appears on Output one rising clk edge after sampling.

---
 rtl/rom_cpu.sv | 48 ++++
 tb/tb_rom_cpu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rom_cpu.sv
// Fixed 16 x 8 program/data ROM for the teaching CPU, with a registered read port.
// Each byte is opcode[7:4] / operand[3:0]; contents are the built-in program image.
module rom_cpu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Address,
  output logic [7:0] Output
);

  logic [7:0] w_rom_data;
  logic [7:0] r_output;

  // Program image; every address is populated so no default value is ever observed.
  always_comb begin
    w_rom_data = 8'h00;
    case (Address)
      4'd0:  w_rom_data = 8'h1E;
      4'd1:  w_rom_data = 8'h2F;
      4'd2:  w_rom_data = 8'h3D;
      4'd3:  w_rom_data = 8'h4C;
      4'd4:  w_rom_data = 8'h5B;
      4'd5:  w_rom_data = 8'hA7;
      4'd6:  w_rom_data = 8'h60;
      4'd7:  w_rom_data = 8'h70;
      4'd8:  w_rom_data = 8'h80;
      4'd9:  w_rom_data = 8'h90;
      4'd10: w_rom_data = 8'h00;
      4'd11: w_rom_data = 8'h00;
      4'd12: w_rom_data = 8'h00;
      4'd13: w_rom_data = 8'h05;
      4'd14: w_rom_data = 8'h03;
      4'd15: w_rom_data = 8'h02;
      default: w_rom_data = 8'h00;
    endcase
  end

  // Reset wins over the read so the CPU starts from a known NOP-like byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_output <= 8'h00;
    end else begin
      r_output <= w_rom_data;
    end
  end

  assign Output = r_output;

endmodule

// File: tb/tb_rom_cpu.sv
// Bench for rom_cpu: directed test-plan steps plus random reads, checked against
// a table-driven model through an expected-value queue on every clock.
module tb_rom_cpu;

  logic       clk;
  logic       rst;
  logic [3:0] Address;
  logic [7:0] Output;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_rom [16];
  logic [7:0] exp_q[$];

  rom_cpu dut (
    .clk     (clk),
    .rst     (rst),
    .Address (Address),
    .Output  (Output)
  );

  // Clock/reset block: 40 ns period.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    model_rom = '{8'h1E, 8'h2F, 8'h3D, 8'h4C, 8'h5B, 8'hA7, 8'h60, 8'h70,
                  8'h80, 8'h90, 8'h00, 8'h00, 8'h00, 8'h05, 8'h03, 8'h02};
  end

  // Model: whatever the inputs are at an edge determines the byte after it.
  always @(posedge clk) begin
    if (rst === 1'b1) exp_q.push_back(8'h00);
    else              exp_q.push_back(model_rom[Address]);
  end

  // Scoreboard: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (Output !== exp_v) begin
        n_err++;
        $display("FAIL model_cmp t=%0t addr=%0d rst=%0b got=%h expected=%h",
                 $time, Address, rst, Output, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] exp_v);
    n_cmp++;
    if (Output !== exp_v) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, Output, exp_v);
    end
  endtask

  // Driver: advance to 10 ns after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #10;
  endtask

  task automatic drive(input logic r, input logic [3:0] a);
    rst = r;
    Address = a;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    Address = 4'd5;
    cycle();
    check("reset_edge1_a5", 8'h00);
    cycle();
    check("reset_edge2_a5", 8'h00);

    drive(1'b0, 4'd0);
    check("first_read_a0", 8'h1E);
    cycle();
    check("hold_a0", 8'h1E);

    Address = 4'd5;
    #5;
    check("midcycle_no_change", 8'h1E);
    cycle();
    check("latency_a5", 8'hA7);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i));
      if (i == 3)  check("sweep_a3", 8'h4C);
      if (i == 9)  check("sweep_a9", 8'h90);
      if (i == 15) check("sweep_a15", 8'h02);
    end
    drive(1'b0, 4'd0);
    check("wrap_a0", 8'h1E);

    for (int i = 0; i < 9; i++) drive(1'b0, 4'(i));
    check("pre_reset_a8", 8'h80);
    drive(1'b1, 4'd9);
    check("midsweep_reset_a9", 8'h00);
    drive(1'b0, 4'd10);
    check("after_reset_a10", 8'h00);
    drive(1'b0, 4'd13);
    check("after_reset_a13", 8'h05);
    drive(1'b0, 4'd14);
    check("after_reset_a14", 8'h03);

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
    end

    rst = 1'b0;
    Address = 4'd1;
    cycle();
    cycle();
    check("final_a1", 8'h2F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
